ipd_stage: RTL and testbench

//  Instruction pre-decode stage, between IF_stage and ID_stage. Accepts {PC_plus_4, 32'b0} plus
//  IF_to_IPD_valid from IF and the synchronous inst RAM read data, and owns the rdata capture buffer.

---
 rtl/ipd_stage_if.sv | 26 ++
 rtl/ipd_stage.sv | 98 +++++++++
 tb/tb_ipd_stage.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ipd_stage_if.sv
// ipd_stage_if: IF -> IPD -> ID handshake and data bundle.
// Revision: 1.0
`default_nettype none

interface ipd_stage_if;
   logic [63:0]  IF_to_IPD_bus;
   logic         IF_to_IPD_valid;
   logic [31:0]  inst_ram_rdata;
   logic         br_cancel;
   logic         ID_allow_in;
   logic         IPD_allow_in;
   logic         IPD_to_ID_valid;
   logic [103:0] IPD_to_ID_bus;

   // master drives the stage (IF/ID neighbours), slave is the stage itself
   modport master (
      output IF_to_IPD_bus, IF_to_IPD_valid, inst_ram_rdata, br_cancel, ID_allow_in,
      input  IPD_allow_in, IPD_to_ID_valid, IPD_to_ID_bus
   );
   modport slave (
      input  IF_to_IPD_bus, IF_to_IPD_valid, inst_ram_rdata, br_cancel, ID_allow_in,
      output IPD_allow_in, IPD_to_ID_valid, IPD_to_ID_bus
   );
endinterface

`default_nettype wire

// File: rtl/ipd_stage.sv
// ipd_stage: instruction pre-decode stage with inst RAM capture buffer.
// Revision: 1.0
`default_nettype none

module ipd_stage #(
   parameter bit          PD_EN      = 1'b1,
   parameter logic [31:0] RESET_INST = 32'h0
) (
   input  wire logic clk,
   input  wire logic reset,
   ipd_stage_if.slave bus
);

   logic        ipd_valid;
   logic        buf_valid;
   logic [31:0] inst_buf;
   logic [31:0] pc_q;
   logic [31:0] inst_q;
   logic [31:0] target_q;
   logic [3:0]  class_q;

   logic        allow_in;
   logic        transfer;
   logic [31:0] sel_inst;
   logic [31:0] in_pc;
   logic [35:0] pd_full;
   logic [35:0] pd;

   wire unused_bus_lo = &{1'b0, bus.IF_to_IPD_bus[31:0]};

   function automatic logic [35:0] predecode(input logic [31:0] inst, input logic [31:0] pc);
      logic [5:0]  op;
      logic [3:0]  cls;
      logic [31:0] tgt;
      op  = inst[31:26];
      cls = 4'b0000;
      tgt = 32'h0;
      if (op == 6'b010100 || op == 6'b010101) begin
         cls = 4'b0001;
         tgt = pc + {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
      end else if (op >= 6'b010110 && op <= 6'b011011) begin
         cls = 4'b0010;
         tgt = pc + {{14{inst[25]}}, inst[25:10], 2'b00};
      end else if (op == 6'b010011) begin
         cls = 4'b0100;
      end else if (op == 6'b001010) begin
         cls = 4'b1000;
      end
      return {cls, tgt};
   endfunction

   assign allow_in = ~ipd_valid | bus.ID_allow_in;
   assign transfer = bus.IF_to_IPD_valid & allow_in & ~bus.br_cancel;
   // RAM data is only valid on first presentation; afterwards the buffer holds it
   assign sel_inst = buf_valid ? inst_buf : bus.inst_ram_rdata;
   assign in_pc    = bus.IF_to_IPD_bus[63:32] - 32'd4;
   assign pd_full  = predecode(sel_inst, in_pc);
   assign pd       = PD_EN ? pd_full : 36'h0;

   always_ff @(posedge clk) begin
      if (reset) begin
         buf_valid <= 1'b0;
         inst_buf  <= 32'h0;
      end else if (bus.br_cancel || transfer) begin
         buf_valid <= 1'b0;
      end else if (bus.IF_to_IPD_valid && !buf_valid) begin
         buf_valid <= 1'b1;
         inst_buf  <= bus.inst_ram_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ipd_valid <= 1'b0;
         pc_q      <= 32'h0;
         inst_q    <= RESET_INST;
         target_q  <= 32'h0;
         class_q   <= 4'h0;
      end else if (bus.br_cancel) begin
         ipd_valid <= 1'b0;
      end else if (transfer) begin
         ipd_valid <= 1'b1;
         pc_q      <= in_pc;
         inst_q    <= sel_inst;
         class_q   <= pd[35:32];
         target_q  <= pd[31:0];
      end else if (bus.ID_allow_in) begin
         ipd_valid <= 1'b0;
      end
   end

   assign bus.IPD_allow_in    = allow_in;
   assign bus.IPD_to_ID_valid = ipd_valid;
   assign bus.IPD_to_ID_bus   = {class_q, target_q, 4'b0000, pc_q, inst_q};

endmodule

`default_nettype wire

// File: tb/tb_ipd_stage.sv
// tb_ipd_stage: directed and random checks of ipd_stage against a transaction model.
// Revision: 1.0
`default_nettype none

module tb_ipd_stage;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   ipd_stage_if bus_if ();
   ipd_stage #(.PD_EN(1'b1), .RESET_INST(32'h0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   int vectors = 0;
   int miscompares = 0;

   // transaction model: output register contents, and the item IF currently holds
   logic         m_valid;
   logic [103:0] m_bus;
   logic         if_have;
   logic         if_first;
   logic [31:0]  if_pc4;
   logic [31:0]  if_inst;

   localparam logic [103:0] c_reset_bus = 104'h0;

   task automatic check(input string tag, input logic [103:0] obs, input logic [103:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [35:0] ref_pd(input logic [31:0] inst, input logic [31:0] pc);
      int          op;
      longint      off;
      logic [31:0] t;
      logic [3:0]  c;
      op = int'(inst[31:26]);
      t  = 32'h0;
      c  = 4'h0;
      if (op == 20 || op == 21) begin
         off = longint'({inst[9:0], inst[25:10]});
         if (off >= 64'd33554432) off = off - 67108864;
         t = pc + 32'(off * 4);
         c = 4'd1;
      end else if (op >= 22 && op <= 27) begin
         off = longint'(inst[25:10]);
         if (off >= 32768) off = off - 65536;
         t = pc + 32'(off * 4);
         c = 4'd2;
      end else if (op == 19) begin
         c = 4'd4;
      end else if (op == 10) begin
         c = 4'd8;
      end
      return {c, t};
   endfunction

   function automatic logic [103:0] ref_bus(input logic [31:0] pc, input logic [31:0] inst);
      logic [35:0] p;
      p = ref_pd(inst, pc);
      return {p[35:32], p[31:0], 4'h0, pc, inst};
   endfunction

   task automatic present(input logic [31:0] pc4, input logic [31:0] inst);
      if_have  = 1'b1;
      if_first = 1'b1;
      if_pc4   = pc4;
      if_inst  = inst;
   endtask

   task automatic cycle(input logic cancel, input logic ida);
      logic allow_exp;
      logic acc;
      bus_if.IF_to_IPD_valid = if_have;
      bus_if.IF_to_IPD_bus   = {if_pc4, 32'h0};
      bus_if.inst_ram_rdata  = (if_have && if_first) ? if_inst : $urandom;
      bus_if.br_cancel       = cancel;
      bus_if.ID_allow_in     = ida;
      allow_exp = ~m_valid | ida;
      #1;
      check("allow_in", {103'h0, bus_if.IPD_allow_in}, {103'h0, allow_exp});
      acc = if_have & allow_exp & ~cancel;
      if (cancel)   m_valid = 1'b0;
      else if (acc) begin m_valid = 1'b1; m_bus = ref_bus(if_pc4 - 32'd4, if_inst); end
      else if (ida) m_valid = 1'b0;
      if (acc || cancel) if_have = 1'b0;
      else               if_first = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("valid", {103'h0, bus_if.IPD_to_ID_valid}, {103'h0, m_valid});
      check("bus", bus_if.IPD_to_ID_bus, m_bus);
   endtask

   task automatic model_reset();
      m_valid  = 1'b0;
      m_bus    = c_reset_bus;
      if_have  = 1'b0;
      if_first = 1'b0;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [5:0] ops [0:10];
      ops = '{6'h14, 6'h15, 6'h16, 6'h17, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h13, 6'h0A, 6'h00};
      return {ops[$urandom_range(0, 10)], 26'($urandom)};
   endfunction

   initial begin
      logic [31:0] pcs;
      bus_if.IF_to_IPD_valid = 1'b0;
      bus_if.IF_to_IPD_bus   = 64'h0;
      bus_if.inst_ram_rdata  = 32'h0;
      bus_if.br_cancel       = 1'b0;
      bus_if.ID_allow_in     = 1'b0;
      model_reset();
      if_pc4  = 32'h0;
      if_inst = 32'h0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", {103'h0, bus_if.IPD_to_ID_valid}, 104'h0);
      check("rst_allow", {103'h0, bus_if.IPD_allow_in}, 104'h1);
      check("rst_bus", bus_if.IPD_to_ID_bus, c_reset_bus);
      reset = 1'b0;

      // single b instruction
      present(32'h1c000004, 32'h50004000);
      cycle(1'b0, 1'b1);
      check("b_target", {72'h0, bus_if.IPD_to_ID_bus[99:68]}, 104'h1c000040);
      check("b_class", {100'h0, bus_if.IPD_to_ID_bus[103:100]}, 104'h1);

      // beq held across a 4-cycle stall with changing RAM data
      present(32'h1c000008, 32'h4c000000);
      cycle(1'b0, 1'b1);
      present(32'h1c00000c, 32'h58000800);
      repeat (4) cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b1);
      check("beq_inst", {72'h0, bus_if.IPD_to_ID_bus[31:0]}, 104'h58000800);
      check("beq_target", {72'h0, bus_if.IPD_to_ID_bus[99:68]}, 104'h1c000010);

      // cancel with a buffered instruction and valid output
      present(32'h1c000010, 32'h28000000);
      cycle(1'b0, 1'b0);
      present(32'h1c000014, 32'h11111111);
      cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      present(32'h1c000100, 32'h02a00000);
      cycle(1'b0, 1'b1);
      check("post_cancel_inst", {72'h0, bus_if.IPD_to_ID_bus[31:0]}, 104'h02a00000);

      // negative offset and wrap
      present(32'h1c000004, 32'h53ffffff);
      cycle(1'b0, 1'b1);
      check("neg_target", {72'h0, bus_if.IPD_to_ID_bus[99:68]}, 104'h1bfffffc);
      present(32'h00000004, 32'h53ffffff);
      cycle(1'b0, 1'b1);
      check("wrap_target", {72'h0, bus_if.IPD_to_ID_bus[99:68]}, 104'hfffffffc);

      // reset while stalled with a buffered instruction
      present(32'h1c000200, 32'h4c000001);
      cycle(1'b0, 1'b0);
      present(32'h1c000204, 32'h33333333);
      cycle(1'b0, 1'b0);
      reset = 1'b1;
      bus_if.ID_allow_in = 1'b0;
      @(posedge clk);
      @(negedge clk);
      model_reset();
      check("rst2_valid", {103'h0, bus_if.IPD_to_ID_valid}, 104'h0);
      check("rst2_allow", {103'h0, bus_if.IPD_allow_in}, 104'h1);
      check("rst2_bus", bus_if.IPD_to_ID_bus, c_reset_bus);
      reset = 1'b0;
      present(32'h1c000300, 32'h5c000400);
      cycle(1'b0, 1'b1);
      check("post_rst_inst", {72'h0, bus_if.IPD_to_ID_bus[31:0]}, 104'h5c000400);

      // back-to-back stream, no bubbles
      for (int i = 0; i < 8; i++) begin
         pcs = 32'h1c001004 + 32'(i * 4);
         present(pcs, rand_inst());
         cycle(1'b0, 1'b1);
         check("stream_valid", {103'h0, bus_if.IPD_to_ID_valid}, 104'h1);
         check("stream_pc", {72'h0, bus_if.IPD_to_ID_bus[63:32]}, {72'h0, pcs - 32'd4});
      end

      // random traffic
      for (int i = 0; i < 400; i++) begin
         if (!if_have && ($urandom_range(0, 3) != 0))
            present({$urandom} & 32'hffff_fffc, rand_inst());
         cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

`default_nettype wire
